// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encodings and default operand width shared by the arithmetic blocks
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder (x, y, ci -> s, co)
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder (start/a/b/cin in; busy/done/sum/cout registered out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_d, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, bit_s, c_d, busy_q, done_q, cout_q;
  full_adder_cell u_fa (.x(a_q[0]), .y(b_q[0]), .ci(c_q), .s(bit_s), .co(c_d));
  assign r_d  = {bit_s, r_q[WIDTH-1:1]};
  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= r_d;
            cout_q  <= c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus multi-cycle corner sequences for serial_adder
module tb_serial_adder;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst, start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t v[8];
  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic go(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
    @(negedge clk);
    a = xa;
    b = xb;
    cin = xc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int k0, output int lat, output int busy_n, output int both);
    lat = k0;
    busy_n = 0;
    both = 0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) both++;
  endtask
  task automatic run_vec(input vec_t t, input string n);
    int lat, bn, both;
    go(t.a, t.b, t.ci);
    wait_done(1, lat, bn, both);
    chk({n, "_latency"}, 32'(lat), 32'd9);
    chk({n, "_busy_cycles"}, 32'(bn), 32'd8);
    chk({n, "_busy_with_done"}, 32'(both), 32'd0);
    chk({n, "_sum"}, 32'(sum), 32'(t.s));
    chk({n, "_cout"}, 32'(cout), 32'(t.co));
    @(negedge clk);
    chk({n, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask
  initial begin
    int lat, bn, both, cnt;
    v[0] = '{8'h25, 8'h1A, 1'b0, 8'h3F, 1'b0};
    v[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    v[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    v[3] = '{8'h10, 8'hFC, 1'b1, 8'h0D, 1'b1};
    v[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    v[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
    v[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    v[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_vec(v[i], $sformatf("vec%0d", i));
    go(8'h01, 8'h01, 1'b0);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, bn, both);
    chk("ignore_latency", 32'(lat), 32'd9);
    chk("ignore_sum", 32'(sum), 32'h02);
    chk("ignore_cout", 32'(cout), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("ignore_extra_done", 32'(cnt), 32'd0);
    go(8'hFF, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("midrst_quiet", 32'(cnt), 32'd0);
    run_vec('{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0}, "after_rst");
    @(negedge clk);
    a = 8'h25; b = 8'h1A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h80; b = 8'h80;
    wait_done(1, lat, bn, both);
    chk("b2b_first_latency", 32'(lat), 32'd9);
    chk("b2b_first_sum", 32'(sum), 32'h3F);
    chk("b2b_first_cout", 32'(cout), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_accepted_busy", 32'(busy), 32'd1);
    lat = 1;
    cnt = 0;
    while (!done && lat < 30) begin
      if (sum !== 8'h3F || cout !== 1'b0) cnt++;
      @(negedge clk);
      lat++;
    end
    chk("b2b_second_latency", 32'(lat), 32'd9);
    chk("b2b_hold_first", 32'(cnt), 32'd0);
    chk("b2b_second_sum", 32'(sum), 32'h00);
    chk("b2b_second_cout", 32'(cout), 32'd1);
    @(negedge clk);
    chk("b2b_done_one_cycle", 32'(done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder; the additive counterpart of the team's full subtractor cell.
- Accepts two WIDTH-bit operands plus carry-in on a start strobe, then processes one bit per clock, LSB first, through a single full-adder cell.
- Presents a registered sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency; pairs with the subtractor blocks in arithmetic datapath exercises.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled on rising edge of clk
a  input  WIDTH  operand A, captured when start is accepted
b  input  WIDTH  operand B, captured when start is accepted
cin  input  1  carry-in, captured when start is accepted
busy  output  1  high while an addition is in progress
done  output  1  single-cycle pulse; sum/cout valid from this cycle on
sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH
cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and bit counter cleared. rst overrides every other input, including mid-operation; any in-flight addition is discarded.
- FSM states:
  - IDLE: busy=0, done=0. If start=1, capture a, b and cin into the operand shift registers and carry flop, set count=0, go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - bit = a_sh[0]^b_sh[0]^carry
    - carry <= majority(a_sh[0], b_sh[0], carry)
    - shift a_sh and b_sh right by one
    - shift bit into the MSB of the accumulating result register
    - count++
    - On the edge where count==WIDTH-1, i.e. the WIDTH-th bit, load sum with the completed result and cout with the final carry, then go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. If start=1 in this cycle, the new operands are accepted exactly as from IDLE and the FSM goes to SHIFT (back-to-back). Otherwise it goes to IDLE.
- Latency: start sampled at edge E0 -> busy=1 after E0 -> done=1 in the cycle following edge E0+WIDTH. Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start in SHIFT: ignored. Operands are not re-captured and there is no error indication.
- sum/cout change only at the completion edge (or reset). They hold their value through IDLE and through any subsequent SHIFT until the next completion. Intermediate partial results are never visible on sum.
- Arithmetic is unsigned modulo 2^WIDTH. cout is bit WIDTH of the true sum. Subtraction a-b is obtained by the caller driving ~b and cin=1; the block itself has no mode input.
- Bit counter width is $clog2(WIDTH)+1. No wrap-around within an operation.
- done and busy are never high together.

Decomposition:
- Shared include file holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to ST_IDLE.
  - A default-width localparam for the arithmetic blocks.
- One sub-module: full_adder_cell, a purely combinational gate-level cell (inputs x, y, ci; outputs s, co), instantiated once in the datapath.
- FSM, counter and shift registers stay in serial_adder.

Test Plan:
- WIDTH=8, a=8'h25, b=8'h1A, cin=0, start one cycle -> busy for 8 cycles, done pulse in the 9th cycle after the start edge; sum=8'h3F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Subtract via inversion: a=8'h10, b=~8'h03=8'hFC, cin=1 -> sum=8'h0D, cout=1 (no borrow).
- Start a=8'h01, b=8'h01; while busy (3rd cycle) pulse start with a=8'hAA, b=8'h55 -> second start ignored; sum=8'h02, cout=0, exactly one done pulse.
- Assert rst for one cycle during SHIFT (4th bit) -> next cycle busy=0, done=0, sum=0, cout=0. A following start with a=8'h7F, b=8'h01 -> sum=8'h80, cout=0.
- Hold start high through the done cycle with new operands a=8'h80, b=8'h80 -> accepted back-to-back; second done 9 cycles after the first; sum=8'h00, cout=1; first result held on sum until the second completes.
